// File: rtl/mem_port_pkg.sv
// Shared types and defaults for the scratch-memory port initiator.
package mem_port_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 8;
    localparam int unsigned DEFAULT_DATA_W = 8;
    localparam int unsigned DEFAULT_DEPTH  = 8;
    localparam int unsigned DEFAULT_LEN_W  = 4;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WR_WAIT    = 3'd1,
        WR_PULSE   = 3'd2,
        RD_SETTLE  = 3'd3,
        RD_PRESENT = 3'd4
    } state_t;

    function automatic int unsigned wrap_inc(input int unsigned a, input int unsigned depth);
        return (a + 1) % depth;
    endfunction

endpackage

// File: rtl/mem_port_master.sv
// Burst read/write initiator for the scratch memory; every memory pin is driven
// straight from a flop so the write strobe is a clean single-cycle pulse.
module mem_port_master
    import mem_port_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned LEN_W  = DEFAULT_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam logic [LEN_W:0]  MAX_LEN  = (LEN_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ADDR_LIM = (ADDR_W+1)'(DEPTH);

    state_t             state;
    logic [LEN_W-1:0]   remaining;
    logic               cmd_bad;
    logic               last_beat;
    logic [ADDR_W-1:0]  addr_next;

    assign cmd_bad   = (cmd_len == '0) || ({1'b0, cmd_len} > MAX_LEN)
                    || ({1'b0, cmd_addr} >= ADDR_LIM);
    assign last_beat = (remaining == LEN_W'(1));
    assign addr_next = ADDR_W'(wrap_inc(32'(mem_address), DEPTH));
    assign busy      = (state != IDLE);

    // mem_address doubles as the burst address counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            remaining   <= '0;
            cmd_ready   <= 1'b0;
            wr_ready    <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            mem_we      <= 1'b0;
            mem_address <= '0;
            mem_data_in <= '0;
        end else begin
            done   <= 1'b0;
            err    <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        if (cmd_bad) begin
                            err <= 1'b1;
                        end else begin
                            cmd_ready   <= 1'b0;
                            mem_address <= cmd_addr;
                            remaining   <= cmd_len;
                            if (cmd_we) begin
                                wr_ready <= 1'b1;
                                state    <= WR_WAIT;
                            end else begin
                                state    <= RD_SETTLE;
                            end
                        end
                    end
                end
                WR_WAIT: begin
                    if (wr_valid && wr_ready) begin
                        mem_data_in <= wr_data;
                        mem_we      <= 1'b1;
                        wr_ready    <= 1'b0;
                        state       <= WR_PULSE;
                    end
                end
                WR_PULSE: begin
                    mem_address <= addr_next;
                    remaining   <= remaining - LEN_W'(1);
                    if (last_beat) begin
                        done      <= 1'b1;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        wr_ready  <= 1'b1;
                        state     <= WR_WAIT;
                    end
                end
                RD_SETTLE: begin
                    rd_data  <= mem_data_out;
                    rd_valid <= 1'b1;
                    state    <= RD_PRESENT;
                end
                RD_PRESENT: begin
                    if (rd_ready) begin
                        rd_valid    <= 1'b0;
                        mem_address <= addr_next;
                        remaining   <= remaining - LEN_W'(1);
                        if (last_beat) begin
                            done      <= 1'b1;
                            cmd_ready <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            state     <= RD_SETTLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_master.sv
// Scoreboard bench for mem_port_master with an 8x8 combinational-read memory model.
module tb_mem_port_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [7:0] cmd_addr = '0;
    logic [3:0] cmd_len = '0;
    logic       wr_valid = 1'b0, wr_ready;
    logic [7:0] wr_data = '0;
    logic       rd_valid, rd_ready = 1'b0;
    logic [7:0] rd_data;
    logic       busy, done, err, mem_we;
    logic [7:0] mem_address, mem_data_in, mem_data_out;

    always #5 clk = ~clk;

    mem_port_master dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .done(done), .err(err),
        .mem_we(mem_we), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    logic [7:0] mem [8];
    assign mem_data_out = mem[mem_address[2:0]];
    always @(posedge clk) if (mem_we) mem[mem_address[2:0]] <= mem_data_in;

    int compared = 0, mismatched = 0;
    int cyc = 0, done_cnt = 0, err_cnt = 0, we_adj = 0, last_we_cyc = -10;
    logic we_prev = 1'b0;
    logic [7:0]  ref_mem [8];
    logic [15:0] exp_wr_q [$];
    logic [15:0] obs_wr_q [$];
    logic [7:0]  exp_rd_q [$];

    function automatic logic [7:0] wrap8(input logic [7:0] a);
        return 8'((a + 8'd1) % 8'd8);
    endfunction

    task automatic tick();
        @(posedge clk); #1;
        cyc++;
        if (mem_we) begin
            obs_wr_q.push_back({mem_address, mem_data_in});
            if (we_prev) we_adj++;
            last_we_cyc = cyc;
        end
        if (done) done_cnt++;
        if (err) err_cnt++;
        we_prev = mem_we;
    endtask

    task automatic send_cmd(input logic we, input logic [7:0] addr, input logic [3:0] len, output int acc);
        int n = 0;
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_len = len;
        while (!cmd_ready && n < 20) begin tick(); n++; end
        compared++;
        if (cmd_ready !== 1'b1) begin
            mismatched++; $display("FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready);
        end
        acc = cyc;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        compared++;
        if ({cmd_ready, wr_ready, rd_valid, busy, done, err, mem_we, mem_address, mem_data_in, rd_data} !== '0) begin
            mismatched++; $display("FAIL reset_outputs: rdy=%b wrdy=%b rv=%b busy=%b done=%b err=%b we=%b a=%h di=%h rd=%h required all 0",
                cmd_ready, wr_ready, rd_valid, busy, done, err, mem_we, mem_address, mem_data_in, rd_data);
        end
        rst = 1'b0;
        tick();
        compared++;
        if (cmd_ready !== 1'b1) begin
            mismatched++; $display("FAIL reset_cmd_ready_rise: cmd_ready=%b required 1", cmd_ready);
        end
    endtask

    task automatic write_burst(input logic [7:0] addr, input logic [3:0] len,
                               input logic [7:0] d0, input logic [7:0] d1,
                               input logic [7:0] d2, input logic [7:0] d3);
        logic [7:0] d [4];
        logic [7:0] a;
        logic [15:0] e, o;
        int acc, n;
        d = '{d0, d1, d2, d3};
        a = addr;
        exp_wr_q.delete(); obs_wr_q.delete(); we_adj = 0; done_cnt = 0;
        for (int i = 0; i < int'(len); i++) begin
            exp_wr_q.push_back({a, d[i]});
            ref_mem[a[2:0]] = d[i];
            a = wrap8(a);
        end
        send_cmd(1'b1, addr, len, acc);
        wr_valid = 1'b1;
        for (int i = 0; i < int'(len); i++) begin
            wr_data = d[i];
            n = 0;
            while (!wr_ready && n < 20) begin tick(); n++; end
            tick();
        end
        n = 0;
        while (!done && n < 20) begin tick(); n++; end
        wr_valid = 1'b0;
        compared++;
        if (done !== 1'b1 || cyc != last_we_cyc + 1) begin
            mismatched++; $display("FAIL wr_done_timing: done=%b at cycle %0d, required 1 at cycle %0d", done, cyc, last_we_cyc + 1);
        end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL wr_busy_after: busy=%b required 0", busy); end
        compared++;
        if (we_adj != 0) begin mismatched++; $display("FAIL wr_we_adjacent: %0d adjacent pulses, required 0", we_adj); end
        compared++;
        if (obs_wr_q.size() != exp_wr_q.size()) begin
            mismatched++; $display("FAIL wr_count: %0d writes, required %0d", obs_wr_q.size(), exp_wr_q.size());
        end
        while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
            e = exp_wr_q.pop_front(); o = obs_wr_q.pop_front();
            compared++;
            if (o !== e) begin mismatched++; $display("FAIL wr_beat: addr/data=%h required %h", o, e); end
        end
    endtask

    task automatic read_burst(input logic [7:0] addr, input logic [3:0] len, input int stall);
        logic [7:0] a, hold_d, hold_a, e;
        logic held_ok;
        int acc, n;
        a = addr;
        exp_rd_q.delete(); obs_wr_q.delete(); done_cnt = 0;
        for (int i = 0; i < int'(len); i++) begin exp_rd_q.push_back(ref_mem[a[2:0]]); a = wrap8(a); end
        send_cmd(1'b0, addr, len, acc);
        a = addr;
        for (int i = 0; i < int'(len); i++) begin
            n = 0;
            while (!rd_valid && n < 20) begin tick(); n++; end
            if (i == 0) begin
                compared++;
                if (cyc - acc != 2) begin mismatched++; $display("FAIL rd_latency: %0d cycles required 2", cyc - acc); end
            end
            if (stall > 0) begin
                held_ok = 1'b1; hold_d = rd_data; hold_a = mem_address;
                for (int s = 0; s < stall; s++) begin
                    tick();
                    if (rd_valid !== 1'b1 || rd_data !== hold_d || mem_address !== hold_a) held_ok = 1'b0;
                end
                compared++;
                if (held_ok !== 1'b1) begin
                    mismatched++; $display("FAIL rd_hold: valid=%b data=%h addr=%h required 1 %h %h", rd_valid, rd_data, mem_address, hold_d, hold_a);
                end
            end
            e = exp_rd_q.pop_front();
            compared++;
            if (rd_valid !== 1'b1 || rd_data !== e) begin
                mismatched++; $display("FAIL rd_beat%0d: valid=%b data=%h required 1 %h", i, rd_valid, rd_data, e);
            end
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
            a = wrap8(a);
            compared++;
            if (mem_address !== a) begin mismatched++; $display("FAIL rd_addr_adv: %h required %h", mem_address, a); end
        end
        compared++;
        if (done !== 1'b1 || done_cnt != 1 || busy !== 1'b0) begin
            mismatched++; $display("FAIL rd_done: done=%b count=%0d busy=%b required 1 1 0", done, done_cnt, busy);
        end
        compared++;
        if (obs_wr_q.size() != 0) begin mismatched++; $display("FAIL rd_no_write: %0d writes required 0", obs_wr_q.size()); end
    endtask

    task automatic test_illegal();
        logic [7:0] addrs [3];
        logic [3:0] lens [3];
        int acc;
        addrs = '{8'd0, 8'd0, 8'd8};
        lens  = '{4'd0, 4'd9, 4'd1};
        for (int k = 0; k < 3; k++) begin
            obs_wr_q.delete(); err_cnt = 0; done_cnt = 0;
            send_cmd(1'b0, addrs[k], lens[k], acc);
            compared++;
            if (err !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
                mismatched++; $display("FAIL illegal%0d_err: err=%b cmd_ready=%b busy=%b required 1 1 0", k, err, cmd_ready, busy);
            end
            tick(); tick();
            compared++;
            if (err_cnt != 1 || done_cnt != 0 || obs_wr_q.size() != 0) begin
                mismatched++; $display("FAIL illegal%0d_pulse: err pulses=%0d done=%0d writes=%0d required 1 0 0", k, err_cnt, done_cnt, obs_wr_q.size());
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int acc, n;
        obs_wr_q.delete(); done_cnt = 0;
        ref_mem[5] = 8'h5A;
        send_cmd(1'b1, 8'd5, 4'd4, acc);
        wr_valid = 1'b1; wr_data = 8'h5A;
        n = 0;
        while (!wr_ready && n < 20) begin tick(); n++; end
        tick();
        tick();
        wr_data = 8'h6B;
        rst = 1'b1;
        tick();
        compared++;
        if ({cmd_ready, wr_ready, rd_valid, busy, done, err, mem_we, mem_address, mem_data_in, rd_data} !== '0) begin
            mismatched++; $display("FAIL midrst_outputs: rdy=%b wrdy=%b we=%b busy=%b done=%b a=%h di=%h required all 0",
                cmd_ready, wr_ready, mem_we, busy, done, mem_address, mem_data_in);
        end
        rst = 1'b0; wr_valid = 1'b0;
        tick();
        compared++;
        if (obs_wr_q.size() != 1 || done_cnt != 0) begin
            mismatched++; $display("FAIL midrst_writes: writes=%0d done=%0d required 1 0", obs_wr_q.size(), done_cnt);
        end else begin
            compared++;
            if (obs_wr_q[0] !== 16'h055A) begin mismatched++; $display("FAIL midrst_beat: %h required 055a", obs_wr_q[0]); end
        end
        compared++;
        if (cmd_ready !== 1'b1) begin mismatched++; $display("FAIL midrst_ready: cmd_ready=%b required 1", cmd_ready); end
        read_burst(8'd5, 4'd1, 0);
    endtask

    initial begin
        test_reset();
        write_burst(8'd2, 4'd3, 8'hA1, 8'hB2, 8'hC3, 8'h00);
        read_burst(8'd2, 4'd3, 0);
        write_burst(8'd6, 4'd4, 8'h11, 8'h22, 8'h33, 8'h44);
        read_burst(8'd0, 4'd2, 0);
        read_burst(8'd2, 4'd2, 5);
        test_illegal();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
